// File: rtl/opl_stats_counters.sv
// opl_stats_counters: packet and lookup statistics for the OPL datapath.
// Snoops ingress/egress streams for start-of-packet beats, counts lookup
// hits and misses, and keeps clear-on-read counters with sticky overflow.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | between packets; the next beat is a start-of-packet
// IN_PKT | inside a multi-beat packet; beats are not counted until tlast
module opl_stats_counters #(
    parameter int COUNT_WIDTH = 32,
    parameter bit SATURATE    = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    input  logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    input  logic                   m_axis_tlast,
    input  logic                   lut_done,
    input  logic                   lut_hit,
    input  logic                   pktin_reg_clear,
    input  logic                   pktout_reg_clear,
    input  logic                   luthit_reg_clear,
    input  logic                   lutmiss_reg_clear,
    output logic [COUNT_WIDTH-1:0] pktin_reg,
    output logic [COUNT_WIDTH-1:0] pktout_reg,
    output logic [COUNT_WIDTH-1:0] luthit_reg,
    output logic [COUNT_WIDTH-1:0] lutmiss_reg,
    output logic [3:0]             ovf_flags
);

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } pkt_state_t;

    localparam logic [COUNT_WIDTH-1:0] ALL_ONES = '1;

    pkt_state_t in_state;
    pkt_state_t in_state_nxt;
    pkt_state_t eg_state;
    pkt_state_t eg_state_nxt;

    logic in_beat;
    logic eg_beat;
    logic in_sop;
    logic eg_sop;

    logic [3:0] evt_raw;
    logic [3:0] evt_q;
    logic [3:0] clr;

    assign in_beat = s_axis_tvalid && s_axis_tready;
    assign eg_beat = m_axis_tvalid && m_axis_tready;

    // Packet-tracking state registers for both snooped streams.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_state <= IDLE;
            eg_state <= IDLE;
        end else begin
            in_state <= in_state_nxt;
            eg_state <= eg_state_nxt;
        end
    end

    // Next-state and SOP decode: any beat accepted while IDLE opens a packet.
    always_comb begin
        in_state_nxt = in_state;
        eg_state_nxt = eg_state;
        in_sop       = 1'b0;
        eg_sop       = 1'b0;

        case (in_state)
            IDLE: begin
                if (in_beat) begin
                    in_sop = 1'b1;
                    if (!s_axis_tlast) in_state_nxt = IN_PKT;
                end
            end
            IN_PKT: begin
                if (in_beat && s_axis_tlast) in_state_nxt = IDLE;
            end
        endcase

        case (eg_state)
            IDLE: begin
                if (eg_beat) begin
                    eg_sop = 1'b1;
                    if (!m_axis_tlast) eg_state_nxt = IN_PKT;
                end
            end
            IN_PKT: begin
                if (eg_beat && m_axis_tlast) eg_state_nxt = IDLE;
            end
        endcase
    end

    // Bit order is shared by events, clears and ovf_flags.
    assign evt_raw = {lut_done && !lut_hit, lut_done && lut_hit, eg_sop, in_sop};
    assign clr     = {lutmiss_reg_clear, luthit_reg_clear, pktout_reg_clear, pktin_reg_clear};

    // Events are registered once to break the input-to-counter timing path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) evt_q <= '0;
        else       evt_q <= evt_raw;
    end

    for (genvar i = 0; i < 4; i++) begin : g_cnt
        logic [COUNT_WIDTH-1:0] cnt_q;
        logic                   ovf_q;

        // Counter with clear-on-read; a clear coinciding with an event keeps the event.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (clr[i]) begin
                cnt_q <= evt_q[i] ? COUNT_WIDTH'(1) : '0;
                ovf_q <= 1'b0;
            end else if (evt_q[i]) begin
                if (cnt_q == ALL_ONES) begin
                    cnt_q <= SATURATE ? ALL_ONES : '0;
                    ovf_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + COUNT_WIDTH'(1);
                end
            end
        end
    end

    assign pktin_reg   = g_cnt[0].cnt_q;
    assign pktout_reg  = g_cnt[1].cnt_q;
    assign luthit_reg  = g_cnt[2].cnt_q;
    assign lutmiss_reg = g_cnt[3].cnt_q;
    assign ovf_flags   = {g_cnt[3].ovf_q, g_cnt[2].ovf_q, g_cnt[1].ovf_q, g_cnt[0].ovf_q};

endmodule

// File: tb/tb_opl_stats_counters.sv
// Bench for opl_stats_counters: three instances (32-bit saturating,
// 4-bit saturating, 4-bit wrapping) share one stimulus stream. A reference
// model pushes expected register snapshots; a monitor pops and compares them.
module tb_opl_stats_counters;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic s_v, s_r, s_l, m_v, m_r, m_l, lut_done, lut_hit;
    logic clr_in, clr_out, clr_hit, clr_miss;

    logic [31:0] d0_pktin, d0_pktout, d0_luthit, d0_lutmiss;
    logic [3:0]  d0_ovf;
    logic [3:0]  s4_pktin, s4_pktout, s4_luthit, s4_lutmiss, s4_ovf;
    logic [3:0]  w4_pktin, w4_pktout, w4_luthit, w4_lutmiss, w4_ovf;

    always #5 clk = ~clk;

    opl_stats_counters u_dut (
        .clk(clk), .reset(reset),
        .s_axis_tvalid(s_v), .s_axis_tready(s_r), .s_axis_tlast(s_l),
        .m_axis_tvalid(m_v), .m_axis_tready(m_r), .m_axis_tlast(m_l),
        .lut_done(lut_done), .lut_hit(lut_hit),
        .pktin_reg_clear(clr_in), .pktout_reg_clear(clr_out),
        .luthit_reg_clear(clr_hit), .lutmiss_reg_clear(clr_miss),
        .pktin_reg(d0_pktin), .pktout_reg(d0_pktout),
        .luthit_reg(d0_luthit), .lutmiss_reg(d0_lutmiss), .ovf_flags(d0_ovf)
    );

    opl_stats_counters #(.COUNT_WIDTH(4), .SATURATE(1'b1)) u_sat4 (
        .clk(clk), .reset(reset),
        .s_axis_tvalid(s_v), .s_axis_tready(s_r), .s_axis_tlast(s_l),
        .m_axis_tvalid(m_v), .m_axis_tready(m_r), .m_axis_tlast(m_l),
        .lut_done(lut_done), .lut_hit(lut_hit),
        .pktin_reg_clear(clr_in), .pktout_reg_clear(clr_out),
        .luthit_reg_clear(clr_hit), .lutmiss_reg_clear(clr_miss),
        .pktin_reg(s4_pktin), .pktout_reg(s4_pktout),
        .luthit_reg(s4_luthit), .lutmiss_reg(s4_lutmiss), .ovf_flags(s4_ovf)
    );

    opl_stats_counters #(.COUNT_WIDTH(4), .SATURATE(1'b0)) u_wrap4 (
        .clk(clk), .reset(reset),
        .s_axis_tvalid(s_v), .s_axis_tready(s_r), .s_axis_tlast(s_l),
        .m_axis_tvalid(m_v), .m_axis_tready(m_r), .m_axis_tlast(m_l),
        .lut_done(lut_done), .lut_hit(lut_hit),
        .pktin_reg_clear(clr_in), .pktout_reg_clear(clr_out),
        .luthit_reg_clear(clr_hit), .lutmiss_reg_clear(clr_miss),
        .pktin_reg(w4_pktin), .pktout_reg(w4_pktout),
        .luthit_reg(w4_luthit), .lutmiss_reg(w4_lutmiss), .ovf_flags(w4_ovf)
    );

    // Actual outputs gathered by instance (k) and counter (i): index k*4+i.
    logic [31:0] a_cnt [12];
    logic [3:0]  a_ovf [3];
    assign a_cnt[0]  = d0_pktin;
    assign a_cnt[1]  = d0_pktout;
    assign a_cnt[2]  = d0_luthit;
    assign a_cnt[3]  = d0_lutmiss;
    assign a_cnt[4]  = 32'(s4_pktin);
    assign a_cnt[5]  = 32'(s4_pktout);
    assign a_cnt[6]  = 32'(s4_luthit);
    assign a_cnt[7]  = 32'(s4_lutmiss);
    assign a_cnt[8]  = 32'(w4_pktin);
    assign a_cnt[9]  = 32'(w4_pktout);
    assign a_cnt[10] = 32'(w4_luthit);
    assign a_cnt[11] = 32'(w4_lutmiss);
    assign a_ovf[0]  = d0_ovf;
    assign a_ovf[1]  = s4_ovf;
    assign a_ovf[2]  = w4_ovf;

    typedef struct packed {
        logic [11:0][31:0] cnt;
        logic [2:0][3:0]   ovf;
    } snap_t;

    snap_t sb_q[$];
    int vectors = 0;
    int errors  = 0;

    function automatic void chk(string name, longint act, longint exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Reference model: packet-level counting by the stated rules.
    int      inst_w [3] = '{32, 4, 4};
    bit      inst_s [3] = '{1'b1, 1'b1, 1'b0};
    longint  mcnt [3][4];
    bit [3:0] movf [3];
    bit      in_pkt_s, in_pkt_m;
    bit [3:0] pend;

    task automatic model_edge();
        bit [3:0] clr_now;
        bit [3:0] ev_now;
        bit sop_s, sop_m;
        snap_t s;
        longint mx;
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < 4; i++) mcnt[k][i] = 0;
                movf[k] = '0;
            end
            pend = '0;
            in_pkt_s = 1'b0;
            in_pkt_m = 1'b0;
        end else begin
            clr_now = {clr_miss, clr_hit, clr_out, clr_in};
            for (int k = 0; k < 3; k++) begin
                mx = (longint'(1) << inst_w[k]) - 1;
                for (int i = 0; i < 4; i++) begin
                    if (clr_now[i]) begin
                        mcnt[k][i] = pend[i] ? 1 : 0;
                        movf[k][i] = 1'b0;
                    end else if (pend[i]) begin
                        if (mcnt[k][i] == mx) begin
                            movf[k][i] = 1'b1;
                            mcnt[k][i] = inst_s[k] ? mx : 0;
                        end else begin
                            mcnt[k][i] = mcnt[k][i] + 1;
                        end
                    end
                end
            end
            sop_s = s_v && s_r && !in_pkt_s;
            sop_m = m_v && m_r && !in_pkt_m;
            if (s_v && s_r) in_pkt_s = !s_l;
            if (m_v && m_r) in_pkt_m = !m_l;
            ev_now = {lut_done && !lut_hit, lut_done && lut_hit, sop_m, sop_s};
            pend = ev_now;
        end
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) s.cnt[k*4+i] = mcnt[k][i][31:0];
            s.ovf[k] = movf[k];
        end
        sb_q.push_back(s);
    endtask

    // Called at a negedge with inputs set; returns at the next negedge.
    task automatic cycle();
        model_edge();
        @(negedge clk);
    endtask

    task automatic quiet();
        s_v = 0; s_r = 0; s_l = 0; m_v = 0; m_r = 0; m_l = 0;
        lut_done = 0; lut_hit = 0;
        clr_in = 0; clr_out = 0; clr_hit = 0; clr_miss = 0;
    endtask

    task automatic idle(int n);
        quiet();
        repeat (n) cycle();
    endtask

    task automatic clear_all();
        quiet();
        clr_in = 1; clr_out = 1; clr_hit = 1; clr_miss = 1;
        cycle();
        idle(2);
    endtask

    // Monitor: compares each expected snapshot just after its clock edge.
    initial begin
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                for (int k = 0; k < 3; k++) begin
                    for (int i = 0; i < 4; i++)
                        chk($sformatf("inst%0d_cnt%0d", k, i), longint'(a_cnt[k*4+i]), longint'(e.cnt[k*4+i]));
                    chk($sformatf("inst%0d_ovf", k), longint'(a_ovf[k]), longint'(e.ovf[k]));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        quiet();
        reset = 1'b1;
        @(negedge clk);
        repeat (2) cycle();
        chk("reset_pktin", longint'(d0_pktin), 0);
        chk("reset_ovf", longint'(d0_ovf), 0);
        reset = 1'b0;
        idle(2);

        // Three-beat ingress packet, then a single-beat packet.
        quiet(); s_v = 1; s_r = 1; s_l = 0; cycle();
        cycle();
        s_l = 1; cycle();
        cycle();
        idle(3);
        chk("ingress_two_pkts", longint'(d0_pktin), 2);

        // Egress with tready toggling; stalled beats must not count.
        clear_all();
        acc = 0;
        for (int i = 0; i < 16; i++) begin
            quiet();
            m_v = 1;
            m_r = logic'(i % 2);
            m_l = (i % 2 == 1) ? logic'(acc % 2) : logic'($urandom_range(0, 1));
            if (m_r) acc++;
            cycle();
        end
        idle(3);
        chk("egress_stalled_pkts", longint'(d0_pktout), 4);

        // Lookup hit, miss, hit, then a clear on the edge of the last hit event.
        clear_all();
        quiet(); lut_done = 1; lut_hit = 1; cycle();
        lut_hit = 0; cycle();
        lut_hit = 1; cycle();
        quiet(); clr_hit = 1; cycle();
        idle(3);
        chk("clear_with_event_hit", longint'(d0_luthit), 1);
        chk("lut_miss_count", longint'(d0_lutmiss), 1);

        // 17 hits and 17 single-beat ingress packets: saturate vs wrap.
        clear_all();
        quiet();
        s_v = 1; s_r = 1; s_l = 1; lut_done = 1; lut_hit = 1;
        repeat (17) cycle();
        idle(3);
        chk("sat4_luthit", longint'(s4_luthit), 15);
        chk("sat4_ovf_hit", longint'(s4_ovf[2]), 1);
        chk("wrap4_pktin", longint'(w4_pktin), 1);
        chk("wrap4_ovf_in", longint'(w4_ovf[0]), 1);
        chk("dflt_luthit_17", longint'(d0_luthit), 17);
        quiet(); clr_hit = 1; cycle();
        idle(2);
        chk("sat4_luthit_cleared", longint'(s4_luthit), 0);
        chk("sat4_ovf_hit_cleared", longint'(s4_ovf[2]), 0);
        chk("sat4_ovf_in_sticky", longint'(s4_ovf[0]), 1);

        // Reset after beat 1 of a 3-beat packet; beat 2 then opens a packet.
        clear_all();
        quiet(); s_v = 1; s_r = 1; s_l = 0; cycle();
        quiet(); reset = 1'b1; cycle();
        chk("midpkt_reset_pktin", longint'(d0_pktin), 0);
        chk("midpkt_reset_ovf", longint'(s4_ovf), 0);
        reset = 1'b0;
        s_v = 1; s_r = 1; s_l = 0; cycle();
        s_l = 1; cycle();
        idle(3);
        chk("midpkt_reset_resume", longint'(d0_pktin), 1);

        // Randomized traffic with occasional clears and resets.
        for (int n = 0; n < 600; n++) begin
            s_v = logic'($urandom_range(0, 3) != 0);
            s_r = logic'($urandom_range(0, 3) != 0);
            s_l = logic'($urandom_range(0, 2) == 0);
            m_v = logic'($urandom_range(0, 1));
            m_r = logic'($urandom_range(0, 3) != 0);
            m_l = logic'($urandom_range(0, 1));
            lut_done = logic'($urandom_range(0, 1));
            lut_hit  = logic'($urandom_range(0, 2) != 0);
            clr_in   = logic'($urandom_range(0, 15) == 0);
            clr_out  = logic'($urandom_range(0, 15) == 0);
            clr_hit  = logic'($urandom_range(0, 15) == 0);
            clr_miss = logic'($urandom_range(0, 15) == 0);
            reset    = logic'($urandom_range(0, 149) == 0);
            cycle();
        end
        reset = 1'b0;
        idle(3);

        repeat (3) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
